// File: rtl/miv_plic_pkg.sv
// rtl/miv_plic_pkg.sv - shared types and defaults for the MIV_PLIC claim engine
package miv_plic_pkg;

  localparam int APB_AW = 32;
  localparam int APB_DW = 32;

  localparam logic [APB_AW-1:0] DEF_PLIC_BASE      = 32'h4000_0000;
  localparam logic [APB_AW-1:0] DEF_ENABLE_OFFSET  = 32'h0000_2000;
  localparam logic [APB_AW-1:0] DEF_CLAIM_OFFSET   = 32'h0020_0004;
  localparam logic [APB_DW-1:0] DEF_ENABLE_MASK    = 32'h0000_00FF;
  localparam int                DEF_TIMEOUT_CYCLES = 256;

  typedef enum logic [2:0] {
    ST_INIT_SETUP,
    ST_INIT_ACCESS,
    ST_IDLE,
    ST_CLAIM_SETUP,
    ST_CLAIM_ACCESS,
    ST_DISPATCH,
    ST_COMPL_SETUP,
    ST_COMPL_ACCESS
  } plic_state_e;

  function automatic logic [APB_AW-1:0] reg_addr(input logic [APB_AW-1:0] base,
                                                 input logic [APB_AW-1:0] offset);
    return base + offset;
  endfunction

endpackage

// File: rtl/miv_apb_initiator_xfer.sv
// rtl/miv_apb_initiator_xfer.sv - single-transfer APB initiator engine
// A start pulse opens the setup phase on the next cycle; the access phase ends on PREADY or timeout.
module miv_apb_initiator_xfer
  import miv_plic_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              write_i,
  input  logic [APB_AW-1:0] addr_i,
  input  logic [APB_DW-1:0] wdata_i,
  input  logic              timeout_i,
  output logic              psel_o,
  output logic              penable_o,
  output logic              pwrite_o,
  output logic [APB_AW-1:0] paddr_o,
  output logic [APB_DW-1:0] pwdata_o,
  input  logic [APB_DW-1:0] prdata_i,
  input  logic              pready_i,
  input  logic              pslverr_i,
  output logic              done_o,
  output logic [APB_DW-1:0] rdata_o,
  output logic              err_o,
  output logic [CNT_W-1:0]  tmo_cnt_o
);

  logic              psel_q;
  logic              penable_q;
  logic              pwrite_q;
  logic [APB_AW-1:0] paddr_q;
  logic [APB_DW-1:0] pwdata_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              access;

  assign access = psel_q & penable_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      cnt_q     <= '0;
    end else if (start_i) begin
      psel_q    <= 1'b1;
      penable_q <= 1'b0;
      pwrite_q  <= write_i;
      paddr_q   <= addr_i;
      pwdata_q  <= wdata_i;
      cnt_q     <= '0;
    end else if (psel_q && !penable_q) begin
      penable_q <= 1'b1;
    end else if (access) begin
      if (pready_i || timeout_i) begin
        psel_q    <= 1'b0;
        penable_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // A late PREADY in the timeout cycle still completes the transfer cleanly.
  assign done_o    = access & (pready_i | timeout_i);
  assign err_o     = access & (pready_i ? pslverr_i : timeout_i);
  assign rdata_o   = prdata_i;
  assign tmo_cnt_o = cnt_q;

  assign psel_o    = psel_q;
  assign penable_o = penable_q;
  assign pwrite_o  = pwrite_q;
  assign paddr_o   = paddr_q;
  assign pwdata_o  = pwdata_q;

endmodule

// File: rtl/miv_plic_claim_engine.sv
// rtl/miv_plic_claim_engine.sv - hardware PLIC enable and claim/complete sequencer
// Programs the enable register after reset, then claims, dispatches and completes each interrupt.
module miv_plic_claim_engine
  import miv_plic_pkg::*;
#(
  parameter logic [APB_AW-1:0] PLIC_BASE      = DEF_PLIC_BASE,
  parameter logic [APB_AW-1:0] ENABLE_OFFSET  = DEF_ENABLE_OFFSET,
  parameter logic [APB_AW-1:0] CLAIM_OFFSET   = DEF_CLAIM_OFFSET,
  parameter logic [APB_DW-1:0] ENABLE_MASK    = DEF_ENABLE_MASK,
  parameter int                TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              PLIC_IRQ,
  output logic [APB_AW-1:0] INITIATOR_PADDR,
  output logic              INITIATOR_PSEL,
  output logic              INITIATOR_PENABLE,
  output logic              INITIATOR_PWRITE,
  output logic [APB_DW-1:0] INITIATOR_PWDATA,
  input  logic [APB_DW-1:0] INITIATOR_PRDATA,
  input  logic              INITIATOR_PREADY,
  input  logic              INITIATOR_PSLVERR,
  output logic              IRQ_VALID,
  output logic [APB_DW-1:0] IRQ_ID,
  input  logic              IRQ_DONE,
  output logic              ERR,
  input  logic              ERR_CLR
);

  localparam int                CNT_W       = $clog2(TIMEOUT_CYCLES);
  localparam logic [APB_AW-1:0] ENABLE_ADDR = reg_addr(PLIC_BASE, ENABLE_OFFSET);
  localparam logic [APB_AW-1:0] CLAIM_ADDR  = reg_addr(PLIC_BASE, CLAIM_OFFSET);

  plic_state_e       state_q;
  logic              irq_valid_q;
  logic [APB_DW-1:0] irq_id_q;
  logic              err_q;

  logic              xfer_start;
  logic              xfer_write;
  logic [APB_AW-1:0] xfer_addr;
  logic [APB_DW-1:0] xfer_wdata;
  logic              xfer_timeout;
  logic              xfer_done;
  logic              xfer_err;
  logic [APB_DW-1:0] xfer_rdata;
  logic [CNT_W-1:0]  xfer_cnt;

  // Transfer requests are decoded from the current state so the setup phase
  // appears on the very next cycle; INIT waits one cycle out of reset first.
  always_comb begin
    xfer_start = 1'b0;
    xfer_write = 1'b0;
    xfer_addr  = CLAIM_ADDR;
    xfer_wdata = irq_id_q;
    case (state_q)
      ST_INIT_SETUP: begin
        if (!INITIATOR_PSEL) begin
          xfer_start = 1'b1;
          xfer_write = 1'b1;
          xfer_addr  = ENABLE_ADDR;
          xfer_wdata = ENABLE_MASK;
        end
      end
      ST_IDLE: begin
        xfer_start = PLIC_IRQ;
      end
      ST_DISPATCH: begin
        xfer_start = IRQ_DONE;
        xfer_write = 1'b1;
      end
      default: ;
    endcase
  end

  assign xfer_timeout = (xfer_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= ST_INIT_SETUP;
      irq_valid_q <= 1'b0;
      irq_id_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      if (xfer_err) begin
        err_q <= 1'b1;
      end else if (ERR_CLR) begin
        err_q <= 1'b0;
      end

      case (state_q)
        ST_INIT_SETUP: begin
          if (INITIATOR_PSEL) state_q <= ST_INIT_ACCESS;
        end
        ST_INIT_ACCESS: begin
          if (xfer_done) state_q <= ST_IDLE;
        end
        ST_IDLE: begin
          if (PLIC_IRQ) state_q <= ST_CLAIM_SETUP;
        end
        ST_CLAIM_SETUP: begin
          state_q <= ST_CLAIM_ACCESS;
        end
        ST_CLAIM_ACCESS: begin
          if (xfer_done) begin
            if (xfer_err) begin
              state_q <= ST_IDLE;
            end else begin
              irq_id_q <= xfer_rdata;
              if (xfer_rdata != '0) begin
                irq_valid_q <= 1'b1;
                state_q     <= ST_DISPATCH;
              end else begin
                state_q <= ST_IDLE;
              end
            end
          end
        end
        ST_DISPATCH: begin
          if (IRQ_DONE) begin
            irq_valid_q <= 1'b0;
            state_q     <= ST_COMPL_SETUP;
          end
        end
        ST_COMPL_SETUP: begin
          state_q <= ST_COMPL_ACCESS;
        end
        ST_COMPL_ACCESS: begin
          if (xfer_done) state_q <= ST_IDLE;
        end
        default: state_q <= ST_INIT_SETUP;
      endcase
    end
  end

  miv_apb_initiator_xfer #(
    .CNT_W (CNT_W)
  ) u_xfer (
    .clk_i     (PCLK),
    .rst_i     (PRESET),
    .start_i   (xfer_start),
    .write_i   (xfer_write),
    .addr_i    (xfer_addr),
    .wdata_i   (xfer_wdata),
    .timeout_i (xfer_timeout),
    .psel_o    (INITIATOR_PSEL),
    .penable_o (INITIATOR_PENABLE),
    .pwrite_o  (INITIATOR_PWRITE),
    .paddr_o   (INITIATOR_PADDR),
    .pwdata_o  (INITIATOR_PWDATA),
    .prdata_i  (INITIATOR_PRDATA),
    .pready_i  (INITIATOR_PREADY),
    .pslverr_i (INITIATOR_PSLVERR),
    .done_o    (xfer_done),
    .rdata_o   (xfer_rdata),
    .err_o     (xfer_err),
    .tmo_cnt_o (xfer_cnt)
  );

  assign IRQ_VALID = irq_valid_q;
  assign IRQ_ID    = irq_id_q;
  assign ERR       = err_q;

endmodule

// File: doc/miv_plic_claim_engine.md
# miv_plic_claim_engine

Hardware APB initiator for the MIV_PLIC target port that performs the PLIC's enable and claim/complete sequences without processor involvement. After reset it programs the PLIC enable register. Each time PLIC_IRQ rises it reads the claim register, hands the claimed source ID to a local handler over a valid/done handshake, and writes the ID back to complete the interrupt. It sits between MIV_PLIC (TARGET_* APB port) and a hardware interrupt dispatcher.

## Interface
- PLIC_BASE, 32'h4000_0000, PLIC APB base address
- ENABLE_OFFSET, 32'h0000_2000, enable register offset
- CLAIM_OFFSET, 32'h0020_0004, claim/complete register offset
- ENABLE_MASK, 32'h0000_00FF, value written to enable register after reset
- TIMEOUT_CYCLES, 256, max access-phase cycles waiting for PREADY (≥2)
- PCLK  in  1  clock; all logic on rising edge
- PRESET  in  1  reset, synchronous, active-high
- PLIC_IRQ  in  1  PLIC interrupt request, level
- INITIATOR_PADDR  out  32  APB address
- INITIATOR_PSEL  out  1  APB select
- INITIATOR_PENABLE  out  1  APB enable
- INITIATOR_PWRITE  out  1  APB direction, 1 = write
- INITIATOR_PWDATA  out  32  APB write data
- INITIATOR_PRDATA  in  32  APB read data
- INITIATOR_PREADY  in  1  APB ready
- INITIATOR_PSLVERR  in  1  APB error
- IRQ_VALID  out  1  claimed ID available to handler
- IRQ_ID  out  32  claimed source ID
- IRQ_DONE  in  1  handler finished; sampled only while IRQ_VALID=1
- ERR  out  1  sticky error (PSLVERR or timeout)
- ERR_CLR  in  1  clears ERR

## Operation
- States: INIT_SETUP, INIT_ACCESS, IDLE, CLAIM_SETUP, CLAIM_ACCESS, DISPATCH, COMPL_SETUP, COMPL_ACCESS.
- Reset: state INIT_SETUP; every output 0; IRQ_ID 0; ERR 0.
- INIT: write ENABLE_MASK to PLIC_BASE+ENABLE_OFFSET, then go to IDLE.
- IDLE: PLIC_IRQ=1 → CLAIM_SETUP. Otherwise hold.
- CLAIM: read PLIC_BASE+CLAIM_OFFSET. When PREADY=1 and PSLVERR=0, capture PRDATA into IRQ_ID. Nonzero ID → DISPATCH. ID 0 (spurious) → IDLE with no completion.
- DISPATCH: IRQ_VALID=1 and IRQ_ID stable until IRQ_DONE=1. Then → COMPL_SETUP.
- COMPL: write IRQ_ID to PLIC_BASE+CLAIM_OFFSET, then go to IDLE.
- Setup phase: PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA valid; lasts exactly 1 cycle.
- Access phase: PSEL=1, PENABLE=1, with all signals held until PREADY=1.
- Idle bus: PSEL=0, PENABLE=0. PADDR/PWDATA hold their last values.
- PSLVERR=1 with PREADY=1: ERR set, transfer ends.
  - INIT → IDLE.
  - CLAIM → IDLE, no dispatch.
  - COMPL → IDLE.
- Timeout: the access-phase counter reaching TIMEOUT_CYCLES without PREADY sets ERR, drops PSEL/PENABLE the next cycle, and takes the same exits as PSLVERR.
- ERR_CLR clears ERR. A set event in the same cycle wins.
- Only one APB transfer is outstanding. Back-to-back transfers always return to PSEL=0 for at least 1 cycle (IDLE or DISPATCH).

## Timing
- From PLIC_IRQ=1 sampled in IDLE:
  - PSEL=1 on the next cycle.
  - PENABLE=1 one cycle after that.
- Zero-wait-state read (PREADY=1 on the first access cycle):
  - IRQ_VALID=1 on the cycle after the access cycle.
  - Total latency from PLIC_IRQ sampled to IRQ_VALID is 3 cycles.
- IRQ_DONE sampled high → IRQ_VALID=0 and PSEL=1 (COMPL_SETUP) on the next cycle.
- Complete write ends → IDLE on the following cycle. PLIC_IRQ still high there starts a new claim 1 cycle later.
- IRQ_DONE while IRQ_VALID=0 is ignored.
- PRESET mid-transfer: PSEL, PENABLE, IRQ_VALID and ERR are 0 after the reset edge. INIT reruns; any in-flight claim is abandoned.
- The timeout counter is TIMEOUT_CYCLES-sized and clears at every setup phase.

## Structure
- Shared package miv_plic_pkg holds:
  - the state enum;
  - default register offsets (ENABLE_OFFSET, CLAIM_OFFSET);
  - APB width constants.
- One natural sub-module, miv_apb_initiator_xfer: a single-transfer APB engine.
  - Inputs: start, write, addr, wdata.
  - Outputs: done, rdata, err (PSLVERR or timeout), and the timeout counter.
  - The top FSM sequences it.

## Test plan
- Reset release, PREADY tied 1:
  - write 0x0000_00FF to 0x4000_2000 within 3 cycles;
  - PSEL then low; ERR=0.
- PLIC_IRQ=1, PRDATA=1 on claim read:
  - read of 0x4020_0004;
  - IRQ_VALID with IRQ_ID=1 3 cycles after IRQ sampled;
  - after IRQ_DONE pulse, write of 0x1 to 0x4020_0004.
- Claim returns 0:
  - no IRQ_VALID, no write;
  - returns to IDLE and re-claims while PLIC_IRQ stays high.
- PREADY held low 2 cycles on the complete write:
  - PADDR/PWDATA/PENABLE stable through the wait;
  - transfer ends on the PREADY cycle.
- PREADY never asserted on the claim:
  - ERR=1 after 256 access cycles;
  - PSEL=0 next cycle, no dispatch;
  - ERR_CLR clears it.
- PRESET asserted during DISPATCH (IRQ_ID=3):
  - IRQ_VALID=0 next cycle;
  - INIT write repeats;
  - no complete write for ID 3.
